// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-ported register file.
package reg_file_pkg;

   // Clear engine state encoding
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   // Default geometry
   localparam int unsigned DEF_WIDTH  = 8;
   localparam int unsigned DEF_ADDR_W = 3;

   // Value written into entries by reset and by the clear sweep
   localparam int unsigned ZERO_VAL = 0;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-entry pending bits: set by lock, cleared by accepted write or clear sweep.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter bit          R0_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic              sweep_en,
   input  logic [ADDR_W-1:0] sweep_addr,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              pend1,
   output logic              pend2
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] pend;

   // Sweep has priority; otherwise clear then set so a same-entry lock wins
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else if (sweep_en) begin
         pend[sweep_addr] <= 1'b0;
      end else begin
         if (clr_en) begin
            pend[clr_addr] <= 1'b0;
         end
         if (set_en && !(R0_ZERO && (set_addr == '0))) begin
            pend[set_addr] <= 1'b1;
         end
      end
   end

   // Combinational pending lookup for both read ports
   always_comb begin
      pend1 = pend[rd_addr1];
      pend2 = pend[rd_addr2];
   end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised 2-read/1-write register file with pending scoreboard and
// sequential clear engine. Optional macro REGFILE_BYPASS_EN forwards the
// in-flight write data and pending-clear to the read ports in the same cycle.
module register_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter bit          R0_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WE3,
   input  logic [ADDR_W-1:0] A3,
   input  logic [WIDTH-1:0]  WD3,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [WIDTH-1:0]  RD1,
   output logic [WIDTH-1:0]  RD2,
   input  logic              lock_en,
   input  logic [ADDR_W-1:0] lock_addr,
   output logic              pend1,
   output logic              pend2,
   input  logic              clr_req,
   output logic              busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   state_e            state;
   logic [ADDR_W-1:0] cnt;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic idle_c;
   logic write_ok_c;
   logic lock_ok_c;
   logic pend_raw1;
   logic pend_raw2;

   // Accepted write/lock qualifiers; the engine drops both while clearing
   always_comb begin
      idle_c     = (state == IDLE);
      write_ok_c = WE3 && idle_c && !(R0_ZERO && (A3 == '0));
      lock_ok_c  = lock_en && idle_c;
   end

   // Clear engine, storage writes and registered busy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         mem   <= '{default: '0};
      end else begin
         case (state)
            IDLE: begin
               if (write_ok_c) begin
                  mem[A3] <= WD3;
               end
               if (clr_req) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               mem[cnt] <= WIDTH'(ZERO_VAL);
               cnt      <= cnt + ADDR_W'(1);
               if (cnt == ADDR_W'(DEPTH - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   reg_file_scoreboard #(
      .ADDR_W  (ADDR_W),
      .R0_ZERO (R0_ZERO)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_en     (lock_ok_c),
      .set_addr   (lock_addr),
      .clr_en     (WE3 && idle_c),
      .clr_addr   (A3),
      .sweep_en   (state == CLEAR),
      .sweep_addr (cnt),
      .rd_addr1   (A1),
      .rd_addr2   (A2),
      .pend1      (pend_raw1),
      .pend2      (pend_raw2)
   );

   // Read ports: hardwired zero, optional same-cycle forwarding, else storage
   always_comb begin
      RD1   = (R0_ZERO && (A1 == '0)) ? WIDTH'(ZERO_VAL) : mem[A1];
      RD2   = (R0_ZERO && (A2 == '0)) ? WIDTH'(ZERO_VAL) : mem[A2];
      pend1 = pend_raw1;
      pend2 = pend_raw2;
`ifdef REGFILE_BYPASS_EN
      if (write_ok_c && (A3 == A1)) begin
         RD1 = WD3;
         if (!(lock_ok_c && (lock_addr == A1))) begin
            pend1 = 1'b0;
         end
      end
      if (write_ok_c && (A3 == A2)) begin
         RD2 = WD3;
         if (!(lock_ok_c && (lock_addr == A2))) begin
            pend2 = 1'b0;
         end
      end
`endif
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised scoreboard bench for register_file_mp (WIDTH=8, ADDR_W=3, R0_ZERO=1).
module tb_register_file_mp;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst, WE3, lock_en, clr_req;
   logic [2:0] A3, A1, A2, lock_addr;
   logic [7:0] WD3, RD1, RD2;
   logic       pend1, pend2, busy;

   register_file_mp #(.WIDTH(8), .ADDR_W(3), .R0_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst), .WE3(WE3), .A3(A3), .WD3(WD3), .A1(A1), .A2(A2),
      .RD1(RD1), .RD2(RD2), .lock_en(lock_en), .lock_addr(lock_addr),
      .pend1(pend1), .pend2(pend2), .clr_req(clr_req), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] rd1;
      logic [7:0] rd2;
      logic       p1;
      logic       p2;
      logic       bsy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: plain arrays plus "entries still to clear" count
   logic [7:0] m_mem [DEPTH];
   logic       m_pend[DEPTH];
   int         clr_left = 0;
   bit         m_valid = 0;

   function automatic logic [7:0] m_read(input int a, input bit wr, input int wa,
                                         input logic [7:0] wd);
      logic [7:0] v;
      v = (a == 0) ? 8'h00 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
      if (wr && wa != 0 && wa == a) v = wd;
`endif
      return v;
   endfunction

   function automatic logic m_pnd(input int a, input bit wr, input int wa,
                                  input bit lk, input int la);
      logic v;
      v = (a == 0) ? 1'b0 : m_pend[a];
`ifdef REGFILE_BYPASS_EN
      if (wr && wa != 0 && wa == a && !(lk && la == a)) v = 1'b0;
`endif
      return v;
   endfunction

   // One clock of stimulus: drive, predict pre-edge outputs, advance model
   task automatic cyc(input bit r, input bit we, input int a3, input int wd,
                      input int a1, input int a2, input bit lk, input int la,
                      input bit cr, input string nm);
      exp_t e;
      bit   idle;
      rst = r; WE3 = we; A3 = 3'(a3); WD3 = 8'(wd); A1 = 3'(a1); A2 = 3'(a2);
      lock_en = lk; lock_addr = 3'(la); clr_req = cr;
      idle = (clr_left == 0);
      if (m_valid && !r) begin
         e.name = nm;
         e.rd1  = m_read(a1, we && idle, a3, 8'(wd));
         e.rd2  = m_read(a2, we && idle, a3, 8'(wd));
         e.p1   = m_pnd(a1, we && idle, a3, lk, la);
         e.p2   = m_pnd(a2, we && idle, a3, lk, la);
         e.bsy  = !idle;
         exp_q.push_back(e);
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_pend[i] = 1'b0; end
         clr_left = 0;
         m_valid  = 1;
      end else if (!idle) begin
         m_mem[DEPTH - clr_left]  = 8'h00;
         m_pend[DEPTH - clr_left] = 1'b0;
         clr_left--;
      end else begin
         if (we && a3 != 0) m_mem[a3] = 8'(wd);
         if (we) m_pend[a3] = 1'b0;
         if (lk && la != 0) m_pend[la] = 1'b1;
         if (cr) clr_left = DEPTH;
      end
      #1;
   endtask

   task automatic rd(input int a1, input int a2, input string nm);
      cyc(0, 0, 0, 0, a1, a2, 0, 0, 0, nm);
   endtask

   // Monitor: outputs are combinational, so every checked cycle presents a result
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp += 5;
         if (RD1 !== e.rd1) begin n_bad++; $display("FAIL %s RD1 got %h want %h", e.name, RD1, e.rd1); end
         if (RD2 !== e.rd2) begin n_bad++; $display("FAIL %s RD2 got %h want %h", e.name, RD2, e.rd2); end
         if (pend1 !== e.p1) begin n_bad++; $display("FAIL %s pend1 got %b want %b", e.name, pend1, e.p1); end
         if (pend2 !== e.p2) begin n_bad++; $display("FAIL %s pend2 got %b want %b", e.name, pend2, e.p2); end
         if (busy !== e.bsy) begin n_bad++; $display("FAIL %s busy got %b want %b", e.name, busy, e.bsy); end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
      // Reset then write
      cyc(0, 1, 5, 'hA7, 5, 3, 0, 0, 0, "wr5");
      rd(5, 3, "rd5");
      // R0 protection
      cyc(0, 1, 0, 'hFF, 0, 5, 0, 0, 0, "wr0");
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, "lock0");
      rd(0, 0, "r0chk");
      // Scoreboard
      cyc(0, 0, 0, 0, 2, 4, 1, 2, 0, "lock2");
      rd(2, 4, "pend2set");
      cyc(0, 1, 2, 'h5A, 2, 4, 0, 0, 0, "wr2");
      rd(2, 4, "pend2clr");
      cyc(0, 1, 4, 'h44, 2, 4, 1, 4, 0, "lockwr4");
      rd(4, 2, "pend4");
      cyc(0, 1, 3, 'h33, 3, 6, 1, 6, 0, "lock6wr3");
      rd(3, 6, "pend6");
      // Clear sweep with a dropped mid-sweep write and lock
      for (int i = 1; i < DEPTH; i++) cyc(0, 1, i, i * 'h11, i, 0, 0, 0, 0, "fill");
      cyc(0, 0, 0, 0, 1, 7, 0, 0, 1, "clrreq");
      for (int i = 0; i < DEPTH; i++)
         cyc(0, (i == 3), 7, 'h99, i, 7 - i, (i == 4), 5, (i == 5), "sweep");
      for (int i = 0; i < DEPTH; i++) rd(i, (i + 3) % DEPTH, "postclr");
      // Reset during the 4th clear cycle
      for (int i = 1; i < DEPTH; i++) cyc(0, 1, i, 'hC0 + i, i, 0, (i == 6), 6, 0, "refill");
      cyc(0, 0, 0, 0, 1, 2, 0, 0, 1, "clr2");
      for (int i = 0; i < 3; i++) rd(5, 6, "clrmid");
      cyc(1, 0, 0, 0, 5, 6, 0, 0, 0, "rstmid");
      for (int i = 0; i < DEPTH; i++) rd(i, 6, "afterrst");
      cyc(0, 1, 6, 'h81, 6, 1, 0, 0, 0, "wrafter");
      rd(6, 1, "rdafter");
      // Same-cycle write and read of the same entry
      cyc(0, 1, 6, 'h3C, 6, 6, 0, 0, 0, "bypass6");
      rd(6, 6, "bypass6next");
      // Randomised traffic
      for (int n = 0; n < 800; n++) begin
         cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
             ($urandom_range(0, 39) == 0), "rand");
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised 2-read/1-write register file. Successor to the fixed 4-entry, 4-bit register file used in the single-cycle processor.
- Generalised in width and depth. Adds an optional hardwired-zero register 0.
- Adds a per-entry pending scoreboard for multi-cycle producers.
- Adds a sequential clear engine that sweeps one entry per cycle.
- Sits in the datapath between decode (A1/A2/A3) and the ALU/writeback stage.

Parameters:
- WIDTH, 8: data width of each register in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W entries.
- R0_ZERO, 1: when 1, entry 0 always reads 0, ignores writes and is never pending.

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- WE3  in  1  write enable for port 3
- A3  in  ADDR_W  write address
- WD3  in  WIDTH  write data
- A1  in  ADDR_W  read address, port 1
- A2  in  ADDR_W  read address, port 2
- RD1  out  WIDTH  read data, port 1 (combinational from A1)
- RD2  out  WIDTH  read data, port 2 (combinational from A2)
- lock_en  in  1  mark entry lock_addr pending (a producer has been issued)
- lock_addr  in  ADDR_W  entry to mark pending
- pend1  out  1  pending bit of entry A1 (combinational)
- pend2  out  1  pending bit of entry A2 (combinational)
- clr_req  in  1  request a sequential clear of all entries
- busy  out  1  high while the clear engine is active

Behaviour:
- Reset (rst=1 at a rising edge):
  - all entries become 0 and all pending bits 0;
  - FSM goes to IDLE, busy=0, sweep counter=0;
  - rst overrides every other input in that cycle, including mid-clear.
- Reads:
  - RD1/RD2 are combinational: mem[A1] and mem[A2]. Zero latency.
  - A1==A2 is legal; both ports return the same value.
  - With R0_ZERO=1, an address of 0 returns 0.
- Writes:
  - When WE3=1 and the FSM is IDLE, mem[A3] <= WD3 at the edge.
  - The new value is visible on RD from the next cycle (subject to the Optional Feature).
  - Writes to entry 0 are dropped when R0_ZERO=1.
- Scoreboard:
  - lock_en=1 sets pend[lock_addr] at the edge.
  - An accepted write (WE3=1 in IDLE) clears pend[A3].
  - Lock and write to the same address in the same cycle: the lock wins and the bit ends at 1.
  - Lock and write to different addresses: both take effect.
  - Entry 0 is never set when R0_ZERO=1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1. The counter loads 0 and busy rises the next cycle.
  - In CLEAR, each cycle: mem[cnt] <= 0, pend[cnt] <= 0, cnt++.
  - CLEAR -> IDLE after writing entry DEPTH-1. Total is exactly DEPTH cycles with busy=1.
  - In CLEAR, WE3 and lock_en are ignored (dropped, not queued). clr_req is ignored.
  - Reads stay valid: cleared entries read 0, uncleared entries read their old value.
  - The counter is ADDR_W wide. Terminal detection is cnt == DEPTH-1, with no overflow past it.
- Widths: no arithmetic on data. The counter wraps naturally and is reset to 0 on entry to CLEAR.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When WE3=1, the FSM is IDLE, the write is not to a zero-hardwired entry, and A3==A1, RD1 returns WD3 in the same cycle. Likewise A3==A2 for RD2.
  - pend1/pend2 read 0 for the entry being written that cycle, unless the same entry is being locked that cycle.
- Undefined: RD and pend show the pre-edge stored values; the new data is visible only after the edge.

Decomposition:
- Package reg_file_pkg:
  - FSM state encoding (IDLE=1'b0, CLEAR=1'b1);
  - default WIDTH/ADDR_W constants;
  - a helper constant for the zero value.
- One natural sub-module, reg_file_scoreboard:
  - holds the DEPTH pending bits with set/clear/clear-sweep inputs;
  - outputs pend1/pend2;
  - parameterised by ADDR_W and R0_ZERO.

Test Plan (WIDTH=8, ADDR_W=3, R0_ZERO=1):
- Reset then write: rst 1 cycle; WE3=1, A3=5, WD3=8'hA7 -> next cycle RD1=8'hA7 with A1=5, and RD2=0 with A2=3.
- R0 protection: WE3=1, A3=0, WD3=8'hFF -> RD1 with A1=0 reads 0; lock_en with lock_addr=0 -> pend1 stays 0.
- Scoreboard:
  - lock_en, lock_addr=2 -> pend1=1 (A1=2);
  - a later WE3 to A3=2 -> pend1=0;
  - a same-cycle lock and write to 4 -> pend=1.
- Clear sweep:
  - fill entries 1-7 with 8'h11..8'h77, pulse clr_req -> busy=1 for exactly 8 cycles;
  - a WE3 issued mid-sweep is dropped;
  - afterwards all reads are 0 and all pend bits are 0.
- Reset mid-clear: rst during the 4th CLEAR cycle -> next cycle busy=0, all entries 0, FSM IDLE, and a new write accepted.
- Bypass (REGFILE_BYPASS_EN defined): WE3=1, A3=A1=6, WD3=8'h3C -> RD1=8'h3C in the same cycle. Without the macro, RD1 shows the old value until the edge.
